// File: rtl/lsu_ecc_scrub_if.sv
// Scrub write-back channel between lsu_ecc_scrub and the DCCM write arbiter.
// The check stage drives a FIFO head (valid/bank/addr/data/ecc) and the
// arbiter accepts it with scrub_ready; a transfer happens when both are high.
//   scrub_valid  head entry present
//   scrub_ready  arbiter accepts the head this cycle
//   scrub_bank   bank index of the head
//   scrub_addr   word address of the head
//   scrub_data   corrected data to write back
//   scrub_ecc    check bits freshly encoded from scrub_data
interface lsu_ecc_scrub_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32,
    parameter int ECC_WIDTH  = 7
);
    logic                  scrub_valid;
    logic                  scrub_ready;
    logic [2:0]            scrub_bank;
    logic [ADDR_WIDTH-1:0] scrub_addr;
    logic [DATA_WIDTH-1:0] scrub_data;
    logic [ECC_WIDTH-1:0]  scrub_ecc;

    modport master (
        output scrub_valid, scrub_bank, scrub_addr, scrub_data, scrub_ecc,
        input  scrub_ready
    );

    modport slave (
        input  scrub_valid, scrub_bank, scrub_addr, scrub_data, scrub_ecc,
        output scrub_ready
    );
endinterface

// File: rtl/lsu_ecc_scrub.sv
// Multi-bank DCCM SEC-DED check stage (DC3 -> DC4).
// Each bank's read data and stored check bits are decoded in DC3; corrected
// data and per-bank single/double error flags are registered into DC4.
// Correctable errors are counted (saturating) and the lowest-index
// single-error bank of each DC4 cycle is queued for write-back scrubbing.
// Ports:
//   clk, rst_l            clock, synchronous active-low reset
//   rd_valid/addr/data/ecc_dc3  per-bank DC3 read inputs (bank b at slice b)
//   ecc_disable           pass raw data, no flags/count/scrub
//   err_clr               clear counter and overflow sticky
//   sec_thresh            threshold for sec_thresh_hit (0 disables)
//   data_dc4, single_err_dc4, double_err_dc4, any_*_dc4   DC4 results
//   sec_cnt, sec_thresh_hit  correctable-error count and threshold flag
//   scrub                 write-back channel (master side)
//   scrub_overflow        sticky: a scrub request was dropped
module lsu_ecc_scrub #(
    parameter int NUM_BANKS  = 2,
    parameter int DATA_WIDTH = 32,
    parameter int ECC_WIDTH  = 7,
    parameter int ADDR_WIDTH = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                            clk,
    input  logic                            rst_l,
    input  logic [NUM_BANKS-1:0]            rd_valid_dc3,
    input  logic [NUM_BANKS*ADDR_WIDTH-1:0] rd_addr_dc3,
    input  logic [NUM_BANKS*DATA_WIDTH-1:0] rd_data_dc3,
    input  logic [NUM_BANKS*ECC_WIDTH-1:0]  rd_ecc_dc3,
    input  logic                            ecc_disable,
    input  logic                            err_clr,
    input  logic [CNT_WIDTH-1:0]            sec_thresh,
    output logic [NUM_BANKS*DATA_WIDTH-1:0] data_dc4,
    output logic [NUM_BANKS-1:0]            single_err_dc4,
    output logic [NUM_BANKS-1:0]            double_err_dc4,
    output logic                            any_single_dc4,
    output logic                            any_double_dc4,
    output logic [CNT_WIDTH-1:0]            sec_cnt,
    output logic                            sec_thresh_hit,
    lsu_ecc_scrub_if.master                 scrub,
    output logic                            scrub_overflow
);

    // Hamming positions run 1..CW-1; the overall parity bit sits outside them.
    localparam int CW   = DATA_WIDTH + ECC_WIDTH;
    localparam int SW   = ECC_WIDTH - 1;
    localparam int PW   = $clog2(FIFO_DEPTH);
    localparam int OW   = PW + 1;
    localparam int SUMW = CNT_WIDTH + 4;
    localparam logic [SW-1:0] MAX_POS = SW'(CW - 1);

    typedef struct packed {
        logic                  single;
        logic                  dbl;
        logic [DATA_WIDTH-1:0] data;
    } dec_t;

    typedef struct packed {
        logic [2:0]            bank;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
        logic [ECC_WIDTH-1:0]  ecc;
    } entry_t;

    // Data bits fill the non-power-of-two positions in ascending order.
    function automatic logic [SW-1:0] ecc_hamming(input logic [DATA_WIDTH-1:0] d);
        logic [SW-1:0] h;
        int            idx;
        h   = '0;
        idx = 0;
        for (int p = 1; p < CW; p++) begin
            if ((p & (p - 1)) != 0) begin
                if (idx < DATA_WIDTH) begin
                    for (int k = 0; k < SW; k++) begin
                        if (p[k]) h[k] = h[k] ^ d[idx];
                    end
                end
                idx++;
            end
        end
        return h;
    endfunction

    function automatic logic [ECC_WIDTH-1:0] ecc_encode(input logic [DATA_WIDTH-1:0] d);
        logic [SW-1:0] h;
        h = ecc_hamming(d);
        return {(^d) ^ (^h), h};
    endfunction

    // Flip the data bit sitting at codeword position syn; check positions
    // never match a data index, so they leave the data untouched.
    function automatic logic [DATA_WIDTH-1:0] ecc_correct(input logic [DATA_WIDTH-1:0] d,
                                                         input logic [SW-1:0]         syn);
        logic [DATA_WIDTH-1:0] r;
        int                    idx;
        r   = d;
        idx = 0;
        for (int p = 1; p < CW; p++) begin
            if ((p & (p - 1)) != 0) begin
                if (idx < DATA_WIDTH && p[SW-1:0] == syn) r[idx] = ~d[idx];
                idx++;
            end
        end
        return r;
    endfunction

    function automatic dec_t ecc_decode(input logic [DATA_WIDTH-1:0] d,
                                        input logic [ECC_WIDTH-1:0]  e,
                                        input logic                  flag_en,
                                        input logic                  corr_en);
        dec_t          r;
        logic [SW-1:0] syn;
        logic          par;
        logic          in_rng;
        syn    = ecc_hamming(d) ^ e[SW-1:0];
        par    = (^d) ^ (^e);
        in_rng = (syn <= MAX_POS);
        r.data   = d;
        r.single = 1'b0;
        r.dbl    = 1'b0;
        if (corr_en && par && in_rng) r.data = ecc_correct(d, syn);
        if (flag_en) begin
            r.single = par && in_rng;
            // An odd-weight error pointing outside the codeword cannot be a
            // single flip, so it is reported as uncorrectable.
            r.dbl    = (!par && syn != '0) || (par && !in_rng);
        end
        return r;
    endfunction

    dec_t                  dec_r [NUM_BANKS];
    logic [NUM_BANKS*ADDR_WIDTH-1:0] addr_dc4;

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_dec
        assign dec_r[b] = ecc_decode(rd_data_dc3[b*DATA_WIDTH +: DATA_WIDTH],
                                     rd_ecc_dc3[b*ECC_WIDTH +: ECC_WIDTH],
                                     rd_valid_dc3[b] && !ecc_disable,
                                     !ecc_disable);
    end

    always_ff @(posedge clk) begin
        if (!rst_l) begin
            data_dc4       <= '0;
            single_err_dc4 <= '0;
            double_err_dc4 <= '0;
            addr_dc4       <= '0;
        end else begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                data_dc4[b*DATA_WIDTH +: DATA_WIDTH] <= dec_r[b].data;
                single_err_dc4[b]                    <= dec_r[b].single;
                double_err_dc4[b]                    <= dec_r[b].dbl;
            end
            addr_dc4 <= rd_addr_dc3;
        end
    end

    assign any_single_dc4 = |single_err_dc4;
    assign any_double_dc4 = |double_err_dc4;

    // DC4 single-error accounting: count, and pick the lowest bank to scrub.
    logic [3:0]            n_single;
    logic [2:0]            sel_bank;
    logic [SUMW-1:0]       cnt_sum;
    logic [CNT_WIDTH-1:0]  cnt_next;
    entry_t                push_entry;

    always_comb begin
        n_single = '0;
        sel_bank = '0;
        for (int b = NUM_BANKS - 1; b >= 0; b--) begin
            if (single_err_dc4[b]) begin
                n_single = n_single + 4'd1;
                sel_bank = 3'(b);
            end
        end
    end

    assign cnt_sum  = {4'b0, sec_cnt} + {{CNT_WIDTH{1'b0}}, n_single};
    assign cnt_next = (|cnt_sum[SUMW-1:CNT_WIDTH]) ? {CNT_WIDTH{1'b1}}
                                                   : cnt_sum[CNT_WIDTH-1:0];

    assign push_entry.bank = sel_bank;
    assign push_entry.addr = addr_dc4[sel_bank*ADDR_WIDTH +: ADDR_WIDTH];
    assign push_entry.data = data_dc4[sel_bank*DATA_WIDTH +: DATA_WIDTH];
    assign push_entry.ecc  = ecc_encode(push_entry.data);

    always_ff @(posedge clk) begin
        if (!rst_l) begin
            sec_cnt <= '0;
        end else if (err_clr) begin
            sec_cnt <= '0;
        end else begin
            sec_cnt <= cnt_next;
        end
    end

    assign sec_thresh_hit = (sec_thresh != '0) && (sec_cnt >= sec_thresh);

    // Scrub FIFO: pointers wrap naturally (power-of-two depth), occupancy
    // kept separately so full and empty are unambiguous.
    entry_t        mem [FIFO_DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [OW-1:0] occ;
    logic          push_req;
    logic          pop;
    logic          full;
    logic          push_ok;
    logic          ovf_evt;
    entry_t        head;

    assign push_req = (n_single != 4'd0);
    assign pop      = (occ != '0) && scrub.scrub_ready;
    assign full     = (occ == OW'(FIFO_DEPTH));
    assign push_ok  = push_req && (!full || pop);
    assign ovf_evt  = (push_req && full && !pop) || (n_single > 4'd1);

    always_ff @(posedge clk) begin
        if (!rst_l) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            occ    <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= push_entry;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (push_ok && !pop) occ <= occ + 1'b1;
            else if (!push_ok && pop) occ <= occ - 1'b1;
        end
    end

    // A new overflow event in the clearing cycle must not be lost.
    always_ff @(posedge clk) begin
        if (!rst_l) begin
            scrub_overflow <= 1'b0;
        end else if (ovf_evt) begin
            scrub_overflow <= 1'b1;
        end else if (err_clr) begin
            scrub_overflow <= 1'b0;
        end
    end

    assign head              = mem[rd_ptr];
    assign scrub.scrub_valid = (occ != '0);
    assign scrub.scrub_bank  = head.bank;
    assign scrub.scrub_addr  = head.addr;
    assign scrub.scrub_data  = head.data;
    assign scrub.scrub_ecc   = head.ecc;

endmodule

// File: tb/tb_lsu_ecc_scrub.sv
module tb_lsu_ecc_scrub;
    localparam int NB = 2;
    localparam int DW = 32;
    localparam int EW = 7;
    localparam int AW = 16;
    localparam int FD = 4;
    localparam int CNTW = 2;
    localparam int CNT_MAX = 3;

    logic              clk;
    logic              rst_l;
    logic [NB-1:0]     rd_valid;
    logic [NB*AW-1:0]  rd_addr;
    logic [NB*DW-1:0]  rd_data;
    logic [NB*EW-1:0]  rd_ecc;
    logic              ecc_disable;
    logic              err_clr;
    logic [CNTW-1:0]   sec_thresh;
    logic [NB*DW-1:0]  data_dc4;
    logic [NB-1:0]     single_err_dc4;
    logic [NB-1:0]     double_err_dc4;
    logic              any_single_dc4;
    logic              any_double_dc4;
    logic [CNTW-1:0]   sec_cnt;
    logic              sec_thresh_hit;
    logic              scrub_overflow;

    lsu_ecc_scrub_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ECC_WIDTH(EW)) sif ();

    lsu_ecc_scrub #(
        .NUM_BANKS(NB), .DATA_WIDTH(DW), .ECC_WIDTH(EW), .ADDR_WIDTH(AW),
        .FIFO_DEPTH(FD), .CNT_WIDTH(CNTW)
    ) dut (
        .clk(clk), .rst_l(rst_l),
        .rd_valid_dc3(rd_valid), .rd_addr_dc3(rd_addr),
        .rd_data_dc3(rd_data), .rd_ecc_dc3(rd_ecc),
        .ecc_disable(ecc_disable), .err_clr(err_clr), .sec_thresh(sec_thresh),
        .data_dc4(data_dc4), .single_err_dc4(single_err_dc4),
        .double_err_dc4(double_err_dc4), .any_single_dc4(any_single_dc4),
        .any_double_dc4(any_double_dc4), .sec_cnt(sec_cnt),
        .sec_thresh_hit(sec_thresh_hit), .scrub(sif),
        .scrub_overflow(scrub_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Encoder written straight from the code definition: data bit i lives at
    // the i-th non-power-of-two position; check bit k covers positions with bit k set.
    function automatic logic [EW-1:0] tb_enc(input logic [DW-1:0] d);
        int            pos [DW];
        int            p;
        logic [EW-1:0] e;
        p = 1;
        for (int i = 0; i < DW; i++) begin
            while ((p & (p - 1)) == 0) p++;
            pos[i] = p;
            p++;
        end
        e = '0;
        for (int k = 0; k < EW - 1; k++)
            for (int i = 0; i < DW; i++)
                if (((pos[i] >> k) & 1) == 1) e[k] = e[k] ^ d[i];
        e[EW-1] = (^d) ^ (^e[EW-2:0]);
        return e;
    endfunction

    // Decoder by search: a codeword is clean, a word one flip away from a
    // codeword is correctable to it, anything else is uncorrectable.
    task automatic tb_dec(input logic [DW-1:0] d, input logic [EW-1:0] e,
                          output logic sgl, output logic dbl, output logic [DW-1:0] dout);
        logic [DW+EW-1:0] w;
        logic [DW+EW-1:0] w2;
        sgl = 1'b0; dbl = 1'b0; dout = d;
        if (tb_enc(d) != e) begin
            w = {e, d};
            for (int j = 0; j < DW + EW; j++) begin
                w2 = w;
                w2[j] = ~w2[j];
                if (!sgl && tb_enc(w2[DW-1:0]) == w2[DW+EW-1:DW]) begin
                    sgl  = 1'b1;
                    dout = w2[DW-1:0];
                end
            end
            dbl = !sgl;
        end
    endtask

    typedef struct {
        logic [2:0]    bank;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [EW-1:0] ecc;
    } ent_t;

    logic [NB*DW-1:0] m_data;
    logic [NB-1:0]    m_vld, m_sgl, m_dbl;
    logic [NB*AW-1:0] m_addr;
    int               m_cnt;
    logic             m_ovf;
    ent_t             q[$];

    task automatic model_update();
        int   nsg;
        logic pop, evt, acc;
        ent_t ent;
        logic s, db;
        logic [DW-1:0] dout;
        if (!rst_l) begin
            m_data = '0; m_vld = '0; m_sgl = '0; m_dbl = '0; m_addr = '0;
            m_cnt = 0; m_ovf = 1'b0; q.delete();
        end else begin
            pop = (q.size() != 0) && sif.scrub_ready;
            nsg = 0;
            for (int b = 0; b < NB; b++) if (m_sgl[b]) nsg++;
            evt = (nsg > 1);
            acc = 1'b0;
            ent = '{default: '0};
            for (int b = NB - 1; b >= 0; b--) begin
                if (m_sgl[b]) begin
                    ent.bank = 3'(b);
                    ent.addr = m_addr[b*AW +: AW];
                    ent.data = m_data[b*DW +: DW];
                    ent.ecc  = tb_enc(ent.data);
                end
            end
            if (nsg > 0) begin
                if (q.size() < FD || pop) acc = 1'b1;
                else evt = 1'b1;
            end
            if (pop) void'(q.pop_front());
            if (acc) q.push_back(ent);
            if (err_clr) m_cnt = 0;
            else m_cnt = (m_cnt + nsg > CNT_MAX) ? CNT_MAX : m_cnt + nsg;
            if (evt) m_ovf = 1'b1;
            else if (err_clr) m_ovf = 1'b0;
            for (int b = 0; b < NB; b++) begin
                tb_dec(rd_data[b*DW +: DW], rd_ecc[b*EW +: EW], s, db, dout);
                if (ecc_disable) begin
                    m_data[b*DW +: DW] = rd_data[b*DW +: DW];
                    m_sgl[b] = 1'b0; m_dbl[b] = 1'b0;
                end else begin
                    m_data[b*DW +: DW] = dout;
                    m_sgl[b] = s && rd_valid[b];
                    m_dbl[b] = db && rd_valid[b];
                end
            end
            m_vld  = rd_valid;
            m_addr = rd_addr;
        end
    endtask

    task automatic check_all();
        for (int b = 0; b < NB; b++)
            if (m_vld[b]) chk($sformatf("data_dc4[%0d]", b), 64'(data_dc4[b*DW +: DW]), 64'(m_data[b*DW +: DW]));
        chk("single_err_dc4", 64'(single_err_dc4), 64'(m_sgl));
        chk("double_err_dc4", 64'(double_err_dc4), 64'(m_dbl));
        chk("any_single_dc4", 64'(any_single_dc4), 64'(|m_sgl));
        chk("any_double_dc4", 64'(any_double_dc4), 64'(|m_dbl));
        chk("sec_cnt", 64'(sec_cnt), 64'(m_cnt));
        chk("sec_thresh_hit", 64'(sec_thresh_hit), 64'(sec_thresh != 0 && m_cnt >= int'(sec_thresh)));
        chk("scrub_valid", 64'(sif.scrub_valid), 64'(q.size() != 0));
        if (q.size() != 0) begin
            chk("scrub_bank", 64'(sif.scrub_bank), 64'(q[0].bank));
            chk("scrub_addr", 64'(sif.scrub_addr), 64'(q[0].addr));
            chk("scrub_data", 64'(sif.scrub_data), 64'(q[0].data));
            chk("scrub_ecc",  64'(sif.scrub_ecc),  64'(q[0].ecc));
        end
        chk("scrub_overflow", 64'(scrub_overflow), 64'(m_ovf));
    endtask

    task automatic cycle();
        model_update();
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    task automatic set_bank(input int b, input logic [DW-1:0] d, input logic [EW-1:0] e,
                            input logic [AW-1:0] a);
        rd_data[b*DW +: DW] = d;
        rd_ecc[b*EW +: EW]  = e;
        rd_addr[b*AW +: AW] = a;
    endtask

    task automatic idle();
        rd_valid = '0;
        err_clr  = 1'b0;
        cycle();
    endtask

    task automatic rand_bank(input int b);
        logic [DW-1:0]    d;
        logic [EW-1:0]    e;
        logic [DW+EW-1:0] w;
        int r, j, k;
        d = $urandom;
        e = tb_enc(d);
        w = {e, d};
        r = $urandom_range(99);
        if (r < 35) begin
            j = $urandom_range(DW + EW - 1);
            w[j] = ~w[j];
        end else if (r < 47) begin
            j = $urandom_range(DW + EW - 1);
            k = (j + 1 + $urandom_range(DW + EW - 2)) % (DW + EW);
            w[j] = ~w[j];
            w[k] = ~w[k];
        end else if (r < 52) begin
            w[DW+EW-1:DW] = EW'($urandom);
        end
        set_bank(b, w[DW-1:0], w[DW+EW-1:DW], AW'($urandom));
    endtask

    typedef struct {
        logic [DW-1:0] d0;
        logic [EW-1:0] e0;
        logic [DW-1:0] d1;
        logic [EW-1:0] e1;
        logic [NB-1:0] vld;
        logic          dis;
        logic [DW-1:0] x0;
        logic [DW-1:0] x1;
        logic [NB-1:0] xs;
        logic [NB-1:0] xd;
    } vec_t;

    vec_t tbl [8];

    initial begin
        logic [DW-1:0] g0, g1;
        logic [EW-1:0] eg0, eg1, e_one;

        rst_l = 1'b0; rd_valid = '0; rd_addr = '0; rd_data = '0; rd_ecc = '0;
        ecc_disable = 1'b0; err_clr = 1'b0; sec_thresh = '0; sif.scrub_ready = 1'b1;

        g0 = 32'hDEAD_BEEF; g1 = 32'h1234_5678;
        eg0 = tb_enc(g0); eg1 = tb_enc(g1); e_one = tb_enc(32'h1);
        tbl[0] = '{g0, eg0, g1, eg1, 2'b11, 1'b0, g0, g1, 2'b00, 2'b00};
        tbl[1] = '{g0 ^ 32'h20, eg0, g1, eg1, 2'b11, 1'b0, g0, g1, 2'b01, 2'b00};
        tbl[2] = '{g0, eg0, g1, eg1 ^ 7'h08, 2'b11, 1'b0, g0, g1, 2'b10, 2'b00};
        tbl[3] = '{g0, eg0 ^ 7'h40, g1, eg1, 2'b11, 1'b0, g0, g1, 2'b01, 2'b00};
        tbl[4] = '{g0, eg0, g1 ^ 32'h8000_0001, eg1, 2'b11, 1'b0, g0, g1 ^ 32'h8000_0001, 2'b00, 2'b10};
        tbl[5] = '{32'h0, 7'h7F, g1 ^ 32'h4, eg1 ^ 7'h01, 2'b11, 1'b0, 32'h0, g1 ^ 32'h4, 2'b00, 2'b11};
        tbl[6] = '{g0 ^ 32'h100, eg0, g1, eg1, 2'b10, 1'b0, g0, g1, 2'b00, 2'b00};
        tbl[7] = '{g0 ^ 32'h2, eg0, g1, eg1, 2'b01, 1'b1, g0 ^ 32'h2, g1, 2'b00, 2'b00};

        // reset state
        cycle();
        cycle();
        chk("rst_data_dc4", data_dc4, 64'h0);
        chk("rst_single", 64'(single_err_dc4), 64'h0);
        chk("rst_sec_cnt", 64'(sec_cnt), 64'h0);
        chk("rst_scrub_valid", 64'(sif.scrub_valid), 64'h0);
        chk("rst_scrub_addr", 64'(sif.scrub_addr), 64'h0);
        chk("rst_scrub_data", 64'(sif.scrub_data), 64'h0);
        chk("rst_overflow", 64'(scrub_overflow), 64'h0);
        rst_l = 1'b1;
        idle();

        // decode vectors
        for (int i = 0; i < 8; i++) begin
            set_bank(0, tbl[i].d0, tbl[i].e0, AW'(16'h0010 + i));
            set_bank(1, tbl[i].d1, tbl[i].e1, AW'(16'h0020 + i));
            rd_valid = tbl[i].vld;
            ecc_disable = tbl[i].dis;
            cycle();
            if (tbl[i].vld[0]) chk($sformatf("tbl%0d_data0", i), 64'(data_dc4[31:0]), 64'(tbl[i].x0));
            if (tbl[i].vld[1]) chk($sformatf("tbl%0d_data1", i), 64'(data_dc4[63:32]), 64'(tbl[i].x1));
            chk($sformatf("tbl%0d_single", i), 64'(single_err_dc4), 64'(tbl[i].xs));
            chk($sformatf("tbl%0d_double", i), 64'(double_err_dc4), 64'(tbl[i].xd));
        end
        ecc_disable = 1'b0;
        for (int i = 0; i < 6; i++) idle();
        err_clr = 1'b1; cycle(); err_clr = 1'b0;

        // single error, bank0 data bit 5
        sif.scrub_ready = 1'b0;
        set_bank(0, 32'h0000_0021, e_one, 16'h0040);
        rd_valid = 2'b01;
        cycle();
        chk("sec_data0", 64'(data_dc4[31:0]), 64'h1);
        chk("sec_single", 64'(single_err_dc4), 64'h1);
        idle();
        chk("sec_cnt1", 64'(sec_cnt), 64'h1);
        chk("sec_scrub_valid", 64'(sif.scrub_valid), 64'h1);
        chk("sec_scrub_bank", 64'(sif.scrub_bank), 64'h0);
        chk("sec_scrub_addr", 64'(sif.scrub_addr), 64'h40);
        chk("sec_scrub_data", 64'(sif.scrub_data), 64'h1);
        chk("sec_scrub_ecc", 64'(sif.scrub_ecc), 64'(e_one));
        idle();
        chk("sec_held", 64'(sif.scrub_addr), 64'h40);
        sif.scrub_ready = 1'b1;
        idle();
        chk("sec_popped", 64'(sif.scrub_valid), 64'h0);

        // double error on bank1
        set_bank(1, g1 ^ 32'h0000_0300, eg1, 16'h0050);
        rd_valid = 2'b10;
        cycle();
        chk("ded_double", 64'(double_err_dc4), 64'h2);
        chk("ded_raw", 64'(data_dc4[63:32]), 64'(g1 ^ 32'h0000_0300));
        idle();
        chk("ded_cnt", 64'(sec_cnt), 64'h1);
        chk("ded_no_push", 64'(sif.scrub_valid), 64'h0);

        // both banks single in one cycle
        set_bank(0, g0 ^ 32'h1, eg0, 16'h0060);
        set_bank(1, g1, eg1 ^ 7'h04, 16'h0061);
        rd_valid = 2'b11;
        cycle();
        idle();
        chk("both_cnt", 64'(sec_cnt), 64'h3);
        chk("both_bank", 64'(sif.scrub_bank), 64'h0);
        chk("both_addr", 64'(sif.scrub_addr), 64'h60);
        chk("both_ovf", 64'(scrub_overflow), 64'h1);
        idle();
        chk("both_one_push", 64'(sif.scrub_valid), 64'h0);
        err_clr = 1'b1; cycle(); err_clr = 1'b0;
        chk("clr_cnt", 64'(sec_cnt), 64'h0);
        chk("clr_ovf", 64'(scrub_overflow), 64'h0);

        // fill FIFO with ready low; fifth push dropped
        sif.scrub_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            set_bank(0, g0 ^ (32'h1 << i), eg0, AW'(16'h0100 + i));
            rd_valid = 2'b01;
            cycle();
        end
        idle();
        chk("full_ovf", 64'(scrub_overflow), 64'h1);
        chk("full_cnt_sat", 64'(sec_cnt), 64'h3);
        sif.scrub_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("drain_valid", 64'(sif.scrub_valid), 64'h1);
            chk("drain_addr", 64'(sif.scrub_addr), 64'(16'h0100 + i));
            chk("drain_data", 64'(sif.scrub_data), 64'(g0));
            idle();
        end
        chk("drain_empty", 64'(sif.scrub_valid), 64'h0);

        // threshold
        err_clr = 1'b1; cycle(); err_clr = 1'b0;
        sec_thresh = 2'd3;
        for (int i = 0; i < 4; i++) begin
            set_bank(1, g1 ^ (32'h10 << i), eg1, AW'(16'h0200 + i));
            rd_valid = 2'b10;
            cycle();
            idle();
            chk("thr_cnt", 64'(sec_cnt), 64'((i + 1 > 3) ? 3 : i + 1));
            chk("thr_hit", 64'(sec_thresh_hit), 64'(i >= 2));
        end
        sec_thresh = '0;
        err_clr = 1'b1; cycle(); err_clr = 1'b0;

        // ecc_disable
        ecc_disable = 1'b1;
        set_bank(0, g0 ^ 32'h8, eg0, 16'h0300);
        rd_valid = 2'b01;
        cycle();
        chk("dis_raw", 64'(data_dc4[31:0]), 64'(g0 ^ 32'h8));
        chk("dis_flags", 64'({single_err_dc4, double_err_dc4}), 64'h0);
        ecc_disable = 1'b0;
        idle();
        chk("dis_cnt", 64'(sec_cnt), 64'h0);
        chk("dis_no_push", 64'(sif.scrub_valid), 64'h0);

        // reset with queued entries
        sif.scrub_ready = 1'b0;
        set_bank(0, g0 ^ 32'h400, eg0, 16'h0400);
        rd_valid = 2'b01;
        cycle();
        set_bank(0, g0 ^ 32'h800, eg0, 16'h0401);
        cycle();
        idle();
        chk("q2_valid", 64'(sif.scrub_valid), 64'h1);
        rst_l = 1'b0;
        cycle();
        chk("rst_mid_valid", 64'(sif.scrub_valid), 64'h0);
        chk("rst_mid_cnt", 64'(sec_cnt), 64'h0);
        rst_l = 1'b1;
        idle();

        // random traffic against the model
        for (int n = 0; n < 3000; n++) begin
            for (int b = 0; b < NB; b++) rand_bank(b);
            rd_valid        = NB'($urandom);
            ecc_disable     = ($urandom_range(9) == 0);
            err_clr         = ($urandom_range(19) == 0);
            sif.scrub_ready = ($urandom_range(1) == 1);
            if ($urandom_range(49) == 0) sec_thresh = CNTW'($urandom);
            rst_l           = ($urandom_range(499) != 0);
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/lsu_ecc_scrub.md
# lsu_ecc_scrub

Parametrised multi-bank DCCM SEC-DED check stage with registered correction, error accounting and write-back scrubbing. It sits between the DCCM read ports (DC3) and the LSU load-data/commit path (DC4). Each bank's read data and stored check bits are decoded, and corrected data and per-bank error flags are registered into DC4. Single-bit errors queue a corrected write-back request into a scrub FIFO drained over a valid/ready handshake to the DCCM write arbiter. A saturating correctable-error counter drives a threshold flag.

## Interface
Parameters:
- NUM_BANKS, 2, number of independently checked DCCM banks (1..8)
- DATA_WIDTH, 32, data bits per bank
- ECC_WIDTH, 7, check bits per bank; must satisfy 2^(ECC_WIDTH-1) >= DATA_WIDTH+ECC_WIDTH
- ADDR_WIDTH, 16, DCCM word address width
- FIFO_DEPTH, 4, scrub FIFO entries (power of two, >=2)
- CNT_WIDTH, 16, correctable-error counter width

Ports:
- clk  in  1  core clock; all state on rising edge
- rst_l  in  1  reset; synchronous, active-low
- rd_valid_dc3  in  NUM_BANKS  bank b read is valid this cycle
- rd_addr_dc3  in  NUM_BANKS*ADDR_WIDTH  word address per bank; bank b at [b*ADDR_WIDTH +: ADDR_WIDTH]
- rd_data_dc3  in  NUM_BANKS*DATA_WIDTH  raw data per bank
- rd_ecc_dc3  in  NUM_BANKS*ECC_WIDTH  stored check bits per bank
- ecc_disable  in  1  suppress detection, correction, counting and scrubbing
- err_clr  in  1  clear counter and overflow sticky
- sec_thresh  in  CNT_WIDTH  threshold; 0 disables the flag
- data_dc4  out  NUM_BANKS*DATA_WIDTH  corrected data
- single_err_dc4  out  NUM_BANKS  correctable error per bank
- double_err_dc4  out  NUM_BANKS  uncorrectable error per bank
- any_single_dc4, any_double_dc4  out  1  OR-reductions of the per-bank flags
- sec_cnt  out  CNT_WIDTH  saturating correctable-error count
- sec_thresh_hit  out  1  sec_thresh!=0 && sec_cnt>=sec_thresh
- scrub_valid  out  1  FIFO head valid
- scrub_ready  in  1  write arbiter accepts head
- scrub_bank  out  3  bank index of head
- scrub_addr  out  ADDR_WIDTH  head address
- scrub_data  out  DATA_WIDTH  corrected data of head
- scrub_ecc  out  ECC_WIDTH  freshly encoded check bits of head
- scrub_overflow  out  1  sticky: a scrub request was dropped

## Operation
- Code definition: data bits occupy codeword positions 1.. that are not powers of two, in ascending order. For k<ECC_WIDTH-1, ecc[k] = XOR of data bits whose position has bit k set. ecc[ECC_WIDTH-1] = XOR of all data bits and ecc[ECC_WIDTH-2:0].
- Decode per bank: syndrome s = recomputed Hamming bits XOR stored ecc[ECC_WIDTH-2:0]; p = overall parity mismatch.
  - p=1, s!=0: single error; flip the data bit at position s. If s is a check position, data is unchanged.
  - p=1, s=0: single error in ecc[ECC_WIDTH-1]; data unchanged.
  - p=0, s!=0: double error; data passed raw.
  - s>DATA_WIDTH+ECC_WIDTH-1 with p=1: treated as double.
- Flags are qualified by rd_valid_dc3 and ~ecc_disable. With ecc_disable=1, raw data passes through.
- Counter: at the end of DC4, sec_cnt += popcount(single_err_dc4), saturating at all-ones. err_clr has priority and loads 0.
- Scrub push: at the end of DC4, one entry is pushed for the lowest-index bank with single_err_dc4 set. The entry holds {bank, addr, corrected data, re-encoded ecc}.
  - Any further single-error banks in the same cycle set scrub_overflow.
  - A push while full, without a same-cycle pop, is dropped and sets scrub_overflow.
  - A simultaneous push and pop while full is accepted.
- Pop occurs when scrub_valid && scrub_ready. Head outputs stay stable while scrub_valid && !scrub_ready.
- Read and write pointers wrap modulo FIFO_DEPTH; occupancy is tracked in a separate counter.
- err_clr clears scrub_overflow; a same-cycle overflow event wins (flag reads 1 next cycle).

## Timing
- DC3 inputs are registered: data_dc4, single_err_dc4, double_err_dc4 and the any_* outputs appear 1 cycle after rd_valid_dc3.
- sec_cnt and sec_thresh_hit update 2 cycles after the erroneous DC3 read.
- scrub_valid rises 2 cycles after the DC3 read when the FIFO was empty.
- Reset values: all DC4 outputs 0, sec_cnt 0, sec_thresh_hit 0, scrub_valid 0, scrub_bank/addr/data/ecc 0, scrub_overflow 0, FIFO empty.
- Reset asserted mid-operation discards FIFO contents and in-flight DC4 flags on the next edge.
- ecc_disable is sampled in DC3. Entries already queued still drain.

## Test plan
- Bank0 data 32'h0000_0001 with correct ecc, bit 5 flipped -> next cycle data_dc4[31:0]=32'h0000_0001, single_err_dc4=2'b01; sec_cnt=1 and scrub entry {0, addr, 32'h1, good ecc} one cycle later.
- Bank1 with two data bits flipped -> double_err_dc4=2'b10, raw data out; no count change, no scrub push.
- Both banks single-error in one cycle -> sec_cnt increments by 2, only bank0 pushed, scrub_overflow=1; then err_clr -> sec_cnt=0, scrub_overflow=0.
- scrub_ready held 0 across 5 single errors with FIFO_DEPTH=4 -> 4 entries held, 5th dropped, overflow=1; release scrub_ready -> 4 pops in FIFO order, pointer wrap verified.
- sec_thresh=3, three single errors -> sec_thresh_hit rises with sec_cnt=3; CNT_WIDTH=2 saturation holds sec_cnt at 3.
- ecc_disable=1 with a single error injected -> raw data out, all flags 0, no count, no push; rst_l low with 2 queued entries -> scrub_valid=0 next cycle.
